uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLK_HZ, default 48000000, meaning the clk48 frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, meaning the line bit rate.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, meaning the byte buffer entries; it SHALL be a power of 2 and at least 2.
REQ-004 SHALL have port clk48  input  1  system clock; the module has one clock only.
REQ-005 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port uart_rx  input  1  asynchronous serial line; idle level is high.
REQ-007 SHALL have port rx_data  output  8  FIFO head byte.
REQ-008 SHALL have port rx_valid  output  1  rx_data is valid.
REQ-009 SHALL have port rx_ready  input  1  consumer accepts rx_data.
REQ-010 SHALL have port rx_level  output  $clog2(FIFO_DEPTH)+1  number of bytes buffered.
REQ-011 SHALL have port rx_frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-012 SHALL have port rx_overflow  output  1  one-cycle pulse when a byte is dropped on full.
REQ-013 SHALL have port rx_parity_err  output  1  one-cycle pulse on a parity mismatch; present only with UART_RX_PARITY_EN.

Function
REQ-014 SHALL pass uart_rx through a 2-flop synchronizer whose flops reset to 1; all sampling uses the synchronized value.
REQ-015 SHALL use bit period P = CLK_HZ/BAUD with integer truncation (416 at the defaults), counted by a down-counter reloaded per bit.
REQ-016 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
REQ-017 IDLE: a synchronized high-to-low edge SHALL cause entry to START with the counter set to P/2.
REQ-018 START: at the half-bit sample, low SHALL cause entry to DATA with the counter set to P; high SHALL be treated as a glitch and cause a return to IDLE, with no pulse.
REQ-019 DATA: SHALL take 8 samples, one every P cycles, shifted in LSB first; after the 8th sample the FSM SHALL go to PARITY if UART_RX_PARITY_EN is defined, otherwise to STOP.
REQ-020 STOP: the sample SHALL be taken P cycles after the previous one; high SHALL push the byte and return to IDLE; low SHALL pulse rx_frame_err, discard the byte, and enter WAIT_IDLE.
REQ-021 WAIT_IDLE: SHALL stay in this state until the synchronized line is high, then go to IDLE; a held-low break therefore yields exactly one rx_frame_err.
REQ-022 The FIFO SHALL be first-word fall-through: rx_valid = (rx_level != 0), and rx_data SHALL equal the oldest byte.
REQ-023 A pop SHALL occur on any cycle with rx_valid and rx_ready both high; rx_data SHALL advance on the next cycle.
REQ-024 The push SHALL occur on the cycle after the stop-bit sample; rx_valid SHALL be high no later than the following cycle.
REQ-025 Push when full with no pop SHALL drop the new byte and pulse rx_overflow; FIFO contents SHALL be unchanged.
REQ-026 Push and pop on the same cycle SHALL both be accepted, including when the FIFO is full; rx_level SHALL be unchanged.
REQ-027 Read and write pointers SHALL wrap modulo FIFO_DEPTH; rx_level SHALL never exceed FIFO_DEPTH.
REQ-028 rx_frame_err, rx_overflow and rx_parity_err SHALL each be registered and high for exactly one cycle per event.

Reset
REQ-029 While rst is high, at each clk48 edge, the FSM SHALL go to IDLE, the pointers and rx_level SHALL be cleared, and the synchronizer SHALL be set to 1.
REQ-030 Reset values SHALL be: rx_valid=0, rx_level=0, rx_data=0, and all error pulses 0.
REQ-031 Reset mid-frame SHALL abandon the partial byte; the first falling edge after rst deasserts SHALL start a fresh frame.

Configuration
REQ-032 With macro UART_RX_PARITY_EN defined, the frame SHALL carry one even-parity bit after the data bits, sampled P cycles after the 8th data bit.
REQ-033 With the macro defined, a parity mismatch SHALL pulse rx_parity_err, discard the byte, and the stop bit SHALL still be checked; a frame with both errors SHALL pulse both.
REQ-034 Without the macro, there SHALL be no parity state, no rx_parity_err port, and the frame SHALL be 8N1.

Verification
REQ-035 Stimulus: 8N1 byte 0x55 at 115200 with rx_ready=0 -> rx_valid=1, rx_data=0x55, rx_level=1, no error pulses.
REQ-036 Stimulus: uart_rx low for 100 cycles, then high -> no push and no pulse; FSM back in IDLE.
REQ-037 Stimulus: byte 0xA3 with stop bit 0, then line low for 3 bit-times -> exactly one rx_frame_err, rx_level=0; next good byte 0x12 is received.
REQ-038 Stimulus: 17 bytes 0x00..0x10 sent with rx_ready=0 -> rx_level=16 and one rx_overflow; then rx_ready=1 drains 0x00..0x0F in order.
REQ-039 Stimulus: rst pulsed for 1 cycle during data bit 4 -> all outputs at reset values; following byte 0x3C is received correctly.
REQ-040 Stimulus with UART_RX_PARITY_EN: 0x07 with parity bit 0 -> rx_parity_err pulse, no push; 0x07 with parity bit 1 -> rx_data=0x07.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) feeding a
// first-word-fall-through byte FIFO, all in the clk48 domain.
module uart_rx_fifo #(
  parameter int CLK_HZ     = 48000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk48,
  input  logic                        rst,
  input  logic                        uart_rx,
  output logic [7:0]                  rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic [$clog2(FIFO_DEPTH):0] rx_level,
  output logic                        rx_frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                        rx_parity_err,
`endif
  output logic                        rx_overflow
);

  localparam int BIT_P  = CLK_HZ / BAUD;
  localparam int HALF_P = BIT_P / 2;
  localparam int CNT_W  = $clog2(BIT_P + 1);
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int LW     = AW + 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_IDLE
  } state_t;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             prev_q, prev_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             push_q, push_d;
  logic [7:0]       push_byte_q, push_byte_d;
  logic             frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
  logic             par_bad_q, par_bad_d;
  logic             parity_err_q, parity_err_d;
`endif

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       mem_q [FIFO_DEPTH];

  logic             rx_s;
  logic             sample;
  logic             pop;
  logic             full;
  logic             wr_en;

  assign rx_s = sync2_q;

  // The edge detector compares against the previous synchronized sample, so
  // the line must be seen high then low after synchronization to start a frame.
  always_comb begin
    sync1_d = uart_rx;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    push_d       = 1'b0;
    push_byte_d  = push_byte_q;
    frame_err_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif
    sample       = (cnt_q == '0);

    unique case (state_q)
      IDLE: begin
        if (prev_q && !rx_s) begin
          state_d = START;
          cnt_d   = CNT_W'(HALF_P - 1);
        end
      end
      START: begin
        if (!sample) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (!rx_s) begin
          state_d = DATA;
          cnt_d   = CNT_W'(BIT_P - 1);
          bit_d   = 3'd0;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (!sample) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          shift_d = {rx_s, shift_q[7:1]};
          cnt_d   = CNT_W'(BIT_P - 1);
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (!sample) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          // Even parity: data bits plus parity bit must hold an even count of ones.
          par_bad_d    = (^shift_q) ^ rx_s;
          parity_err_d = (^shift_q) ^ rx_s;
          cnt_d        = CNT_W'(BIT_P - 1);
          state_d      = STOP;
        end
      end
`endif
      STOP: begin
        if (!sample) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (rx_s) begin
`ifdef UART_RX_PARITY_EN
          push_d = !par_bad_q;
`else
          push_d = 1'b1;
`endif
          push_byte_d = shift_q;
          state_d     = IDLE;
        end else begin
          frame_err_d = 1'b1;
          state_d     = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk48) begin
    if (rst) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      prev_q       <= 1'b1;
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      push_q       <= 1'b0;
      push_byte_q  <= '0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      prev_q       <= prev_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      push_q       <= push_d;
      push_byte_q  <= push_byte_d;
      frame_err_q  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // A pop frees a slot in the same cycle, so push-on-full is accepted when popping.
  always_comb begin
    pop        = rx_valid && rx_ready;
    full       = (level_q == LW'(FIFO_DEPTH));
    wr_en      = push_q && (!full || pop);
    overflow_d = push_q && full && !pop;
    wr_ptr_d   = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d    = level_q;
    if (wr_en && !pop) begin
      level_d = level_q + LW'(1);
    end else if (!wr_en && pop) begin
      level_d = level_q - LW'(1);
    end
  end

  always_ff @(posedge clk48) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk48) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= push_byte_q;
    end
  end

  assign rx_valid     = (level_q != '0);
  assign rx_level     = level_q;
  assign rx_data      = rx_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign rx_frame_err = frame_err_q;
  assign rx_overflow  = overflow_q;
`ifdef UART_RX_PARITY_EN
  assign rx_parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo; runs a short bit period (40 clocks) to keep
// frame sequences fast. Honors UART_RX_PARITY_EN when defined.
module tb_uart_rx_fifo;

  localparam int CLK_HZ_TB = 4608000;
  localparam int BAUD_TB   = 115200;
  localparam int DEPTH     = 16;
  localparam int P         = CLK_HZ_TB / BAUD_TB;
`ifdef UART_RX_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  logic       clk48 = 1'b0;
  logic       rst = 1'b1;
  logic       uart_rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [4:0] rx_level;
  logic       rx_frame_err;
  logic       rx_overflow;
`ifdef UART_RX_PARITY_EN
  logic       rx_parity_err;
`endif

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
`ifdef UART_RX_PARITY_EN
  int pe_cnt = 0;
`endif

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         tail;
    int         exp_level;
    logic [7:0] exp_data;
    int         exp_fe;
  } vec_t;

  vec_t vecs [7];

  uart_rx_fifo #(
    .CLK_HZ    (CLK_HZ_TB),
    .BAUD      (BAUD_TB),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk48        (clk48),
    .rst          (rst),
    .uart_rx      (uart_rx),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_level     (rx_level),
    .rx_frame_err (rx_frame_err),
`ifdef UART_RX_PARITY_EN
    .rx_parity_err(rx_parity_err),
`endif
    .rx_overflow  (rx_overflow)
  );

  always #10 clk48 = ~clk48;

  // Count high cycles of each pulse so a stretched pulse shows up as an extra event.
  always @(negedge clk48) begin
    if (rx_frame_err) fe_cnt <= fe_cnt + 1;
    if (rx_overflow)  ov_cnt <= ov_cnt + 1;
`ifdef UART_RX_PARITY_EN
    if (rx_parity_err) pe_cnt <= pe_cnt + 1;
`endif
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk48);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit, input int tail_low,
                               input logic par_en, input logic par_bit);
    uart_rx = 1'b0;
    waitCycles(P);
    for (int i = 0; i < 8; i++) begin
      uart_rx = data[i];
      waitCycles(P);
    end
    if (par_en) begin
      uart_rx = par_bit;
      waitCycles(P);
    end
    uart_rx = stop_bit;
    waitCycles(P);
    if (tail_low > 0) begin
      uart_rx = 1'b0;
      waitCycles(tail_low * P);
    end
    uart_rx = 1'b1;
    waitCycles(2 * P);
  endtask

  task automatic drainFifo(input string name);
    rx_ready = 1'b1;
    for (int i = 0; i < DEPTH + 4 && rx_valid; i++) waitCycles(1);
    rx_ready = 1'b0;
    checkOutput(name, 32'(rx_level), 32'd0);
  endtask

  initial begin
    int fe0;
    int ov0;
    logic [7:0] b;

    vecs[0] = '{data: 8'h55, stop: 1'b1, tail: 0, exp_level: 1, exp_data: 8'h55, exp_fe: 0};
    vecs[1] = '{data: 8'hA3, stop: 1'b0, tail: 3, exp_level: 0, exp_data: 8'h00, exp_fe: 1};
    vecs[2] = '{data: 8'h12, stop: 1'b1, tail: 0, exp_level: 1, exp_data: 8'h12, exp_fe: 0};
    vecs[3] = '{data: 8'hFF, stop: 1'b1, tail: 0, exp_level: 1, exp_data: 8'hFF, exp_fe: 0};
    vecs[4] = '{data: 8'h00, stop: 1'b1, tail: 0, exp_level: 1, exp_data: 8'h00, exp_fe: 0};
    vecs[5] = '{data: 8'h80, stop: 1'b0, tail: 0, exp_level: 0, exp_data: 8'h00, exp_fe: 1};
    vecs[6] = '{data: 8'h01, stop: 1'b1, tail: 0, exp_level: 1, exp_data: 8'h01, exp_fe: 0};

    rst = 1'b1;
    waitCycles(3);
    checkOutput("reset_valid", 32'(rx_valid), 32'd0);
    checkOutput("reset_level", 32'(rx_level), 32'd0);
    checkOutput("reset_data", 32'(rx_data), 32'd0);
    checkOutput("reset_frame_err", 32'(rx_frame_err), 32'd0);
    checkOutput("reset_overflow", 32'(rx_overflow), 32'd0);
    rst = 1'b0;
    waitCycles(2 * P);

    // Short low glitch: START must reject it at the half-bit sample.
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    uart_rx = 1'b0;
    waitCycles(P / 4);
    uart_rx = 1'b1;
    waitCycles(2 * P);
    checkOutput("glitch_level", 32'(rx_level), 32'd0);
    checkOutput("glitch_fe", 32'(fe_cnt - fe0), 32'd0);
    checkOutput("glitch_ov", 32'(ov_cnt - ov0), 32'd0);
    applyStimulus(8'h5A, 1'b1, 0, PAR_EN, ^8'h5A);
    checkOutput("post_glitch_level", 32'(rx_level), 32'd1);
    checkOutput("post_glitch_data", 32'(rx_data), 32'h5A);
    drainFifo("post_glitch_drain");

    for (int i = 0; i < 7; i++) begin
      fe0 = fe_cnt;
      ov0 = ov_cnt;
      applyStimulus(vecs[i].data, vecs[i].stop, vecs[i].tail, PAR_EN, ^vecs[i].data);
      checkOutput($sformatf("v%0d_level", i), 32'(rx_level), 32'(vecs[i].exp_level));
      checkOutput($sformatf("v%0d_valid", i), 32'(rx_valid), 32'(vecs[i].exp_level != 0));
      if (vecs[i].exp_level != 0)
        checkOutput($sformatf("v%0d_data", i), 32'(rx_data), 32'(vecs[i].exp_data));
      checkOutput($sformatf("v%0d_fe", i), 32'(fe_cnt - fe0), 32'(vecs[i].exp_fe));
      checkOutput($sformatf("v%0d_ov", i), 32'(ov_cnt - ov0), 32'd0);
      drainFifo($sformatf("v%0d_drain", i));
    end

    // Fill past capacity: 17th byte dropped with one overflow pulse.
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    for (int n = 0; n < 17; n++) begin
      b = 8'(n);
      applyStimulus(b, 1'b1, 0, PAR_EN, ^b);
    end
    checkOutput("full_level", 32'(rx_level), 32'd16);
    checkOutput("full_ov", 32'(ov_cnt - ov0), 32'd1);
    checkOutput("full_fe", 32'(fe_cnt - fe0), 32'd0);
    for (int n = 0; n < 16; n++) begin
      checkOutput($sformatf("drain%0d_valid", n), 32'(rx_valid), 32'd1);
      checkOutput($sformatf("drain%0d_data", n), 32'(rx_data), 32'(n));
      rx_ready = 1'b1;
      waitCycles(1);
      rx_ready = 1'b0;
    end
    checkOutput("drained_level", 32'(rx_level), 32'd0);

    // Reset pulse during data bit 4 of a partial frame.
    applyStimulus(8'h99, 1'b1, 0, PAR_EN, ^8'h99);
    checkOutput("pre_rst_level", 32'(rx_level), 32'd1);
    b = 8'hC3;
    uart_rx = 1'b0;
    waitCycles(P);
    for (int i = 0; i < 4; i++) begin
      uart_rx = b[i];
      waitCycles(P);
    end
    uart_rx = b[4];
    waitCycles(P / 2);
    rst = 1'b1;
    waitCycles(1);
    rst = 1'b0;
    uart_rx = 1'b1;
    checkOutput("midrst_valid", 32'(rx_valid), 32'd0);
    checkOutput("midrst_level", 32'(rx_level), 32'd0);
    checkOutput("midrst_data", 32'(rx_data), 32'd0);
    checkOutput("midrst_frame_err", 32'(rx_frame_err), 32'd0);
    checkOutput("midrst_overflow", 32'(rx_overflow), 32'd0);
    waitCycles(2 * P);
    fe0 = fe_cnt;
    applyStimulus(8'h3C, 1'b1, 0, PAR_EN, ^8'h3C);
    checkOutput("post_rst_level", 32'(rx_level), 32'd1);
    checkOutput("post_rst_data", 32'(rx_data), 32'h3C);
    checkOutput("post_rst_fe", 32'(fe_cnt - fe0), 32'd0);
    drainFifo("post_rst_drain");

`ifdef UART_RX_PARITY_EN
    begin
      int pe0;
      pe0 = pe_cnt;
      applyStimulus(8'h07, 1'b1, 0, 1'b1, 1'b0);
      checkOutput("par_bad_pe", 32'(pe_cnt - pe0), 32'd1);
      checkOutput("par_bad_level", 32'(rx_level), 32'd0);
      pe0 = pe_cnt;
      applyStimulus(8'h07, 1'b1, 0, 1'b1, 1'b1);
      checkOutput("par_ok_pe", 32'(pe_cnt - pe0), 32'd0);
      checkOutput("par_ok_level", 32'(rx_level), 32'd1);
      checkOutput("par_ok_data", 32'(rx_data), 32'h07);
      drainFifo("par_drain");
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
